// File: rtl/pattern_gen_if.sv
// Valid/ready stream bundle between pattern_gen (master) and the ping-pong buffer write side (slave).
interface pattern_gen_if #(
  parameter int DATA_W = 16
) ();
  logic              data_en;
  logic [DATA_W-1:0] data_in;
  logic              data_ready;
  logic              burst_done;

  modport master (
    output data_en,
    output data_in,
    output burst_done,
    input  data_ready
  );

  modport slave (
    input  data_en,
    input  data_in,
    input  burst_done,
    output data_ready
  );
endinterface

// File: rtl/pattern_gen.sv
// Burst-framed counting/LFSR/walking-one stimulus source with valid/ready backpressure.
// Optional one-shot bit-0 error injection is built only when PATTERN_GEN_ERR_INJ_EN is defined.
module pattern_gen #(
  parameter int          DATA_W    = 16,
  parameter int          WRAP_MAX  = 199,
  parameter logic [31:0] LFSR_POLY = 32'h0000_002D,
  parameter int          LFSR_SEED = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [1:0]    mode,
  input  logic [7:0]    burst_len,
  input  logic [7:0]    gap_len,
  input  logic          inject_err,
  pattern_gen_if.master bus
);

  localparam logic [DATA_W-1:0] ONE_L  = DATA_W'(1);
  localparam logic [DATA_W-1:0] WRAP_L = DATA_W'(WRAP_MAX);
  localparam logic [DATA_W-1:0] POLY_L = LFSR_POLY[DATA_W-1:0];
  localparam logic [DATA_W-1:0] SEED_T = DATA_W'(LFSR_SEED);
  // An all-zero LFSR state would lock up, so a zero seed is forced to 1.
  localparam logic [DATA_W-1:0] SEED_L = (SEED_T == '0) ? ONE_L : SEED_T;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [1:0] M_INC  = 2'd0;
  localparam logic [1:0] M_DEC  = 2'd1;
  localparam logic [1:0] M_LFSR = 2'd2;

  function automatic logic [DATA_W-1:0] seed_of(input logic [1:0] m);
    case (m)
      M_INC:   seed_of = '0;
      M_DEC:   seed_of = WRAP_L;
      M_LFSR:  seed_of = SEED_L;
      default: seed_of = ONE_L;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] next_of(input logic [1:0] m, input logic [DATA_W-1:0] q);
    case (m)
      M_INC:   next_of = (q >= WRAP_L) ? '0 : q + ONE_L;
      M_DEC:   next_of = (q == '0) ? WRAP_L : q - ONE_L;
      M_LFSR:  next_of = {q[DATA_W-2:0], 1'b0} ^ (q[DATA_W-1] ? POLY_L : '0);
      default: next_of = {q[DATA_W-2:0], q[DATA_W-1]};
    endcase
  endfunction

  logic [1:0]        state_q,    state_d;
  logic [1:0]        mode_q,     mode_d;
  logic [7:0]        blen_q,     blen_d;
  logic [7:0]        glen_q,     glen_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [7:0]        gap_cnt_q,  gap_cnt_d;
  logic [DATA_W-1:0] pat_q,      pat_d;
  logic              done_q,     done_d;

  logic valid;
  logic beat;
  logic last_beat;

  assign valid     = (state_q == S_BURST);
  assign beat      = valid & bus.data_ready;
  assign last_beat = beat & (blen_q != 8'd0) & (beat_cnt_q == blen_q - 8'd1);

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no branch below can leave one unassigned and infer a latch.
    state_d    = state_q;
    mode_d     = mode_q;
    blen_d     = blen_q;
    glen_d     = glen_q;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    pat_d      = pat_q;
    done_d     = last_beat;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d    = S_BURST;
          mode_d     = mode;
          blen_d     = burst_len;
          glen_d     = gap_len;
          beat_cnt_d = '0;
          gap_cnt_d  = '0;
          pat_d      = seed_of(mode);
        end
      end

      S_BURST: begin
        if (beat) begin
          pat_d      = next_of(mode_q, pat_q);
          beat_cnt_d = last_beat ? 8'd0 : beat_cnt_q + 8'd1;
          if (!enable) begin
            state_d = S_IDLE;
          end else if (last_beat) begin
            if (glen_q != 8'd0) begin
              state_d   = S_GAP;
              gap_cnt_d = '0;
            end else begin
              // Back-to-back bursts: pick up new framing without a bubble.
              blen_d = burst_len;
              glen_d = gap_len;
            end
          end
        end
      end

      S_GAP: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q == glen_q) begin
          // The burst_done cycle plus glen_q idle cycles have elapsed.
          state_d    = S_BURST;
          blen_d     = burst_len;
          glen_d     = gap_len;
          beat_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= M_INC;
      blen_q     <= '0;
      glen_q     <= '0;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
      pat_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking updates make every register sample the pre-edge values, whatever the statement order.
      state_q    <= state_d;
      mode_q     <= mode_d;
      blen_q     <= blen_d;
      glen_q     <= glen_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      pat_q      <= pat_d;
      done_q     <= done_d;
    end
  end

  assign bus.data_en    = valid;
  assign bus.burst_done = done_q;

`ifdef PATTERN_GEN_ERR_INJ_EN
  logic err_q, err_d;

  // Requests arriving while armed merge into the pending one; the flag drops on the corrupted beat.
  always_comb begin
    err_d = err_q ? ~beat : inject_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.data_in = pat_q ^ {{(DATA_W-1){1'b0}}, err_q};
`else
  logic unused_inject_err;
  assign unused_inject_err = inject_err;
  assign bus.data_in       = pat_q;
`endif

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: a spec-level cycle model checks the 16-bit instance every cycle,
// literal sequences pin framing, backpressure, LFSR (8-bit instance) and error injection.
module tb_pattern_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       enable;
  logic [1:0] mode;
  logic [7:0] burst_len;
  logic [7:0] gap_len;
  logic       inject_err;
  logic       en8;

  pattern_gen_if #(.DATA_W(16)) bus16 ();
  pattern_gen_if #(.DATA_W(8))  bus8 ();

  pattern_gen #(.DATA_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .mode       (mode),
    .burst_len  (burst_len),
    .gap_len    (gap_len),
    .inject_err (inject_err),
    .bus        (bus16.master)
  );

  pattern_gen #(.DATA_W(8), .WRAP_MAX(199), .LFSR_POLY(32'h1D), .LFSR_SEED(1)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (en8),
    .mode       (2'd2),
    .burst_len  (8'd0),
    .gap_len    (8'd0),
    .inject_err (1'b0),
    .bus        (bus8.master)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word number k of a freshly seeded stream, straight from the pattern definitions.
  function automatic logic [15:0] m_word(input int md, input int k);
    logic [15:0] v;
    case (md)
      0: v = 16'(k % 200);
      1: v = 16'(199 - (k % 200));
      2: begin
        v = 16'h0001;
        for (int i = 0; i < k; i++) v = v[15] ? ((v << 1) ^ 16'h002D) : (v << 1);
      end
      default: v = 16'h0001 << (k % 16);
    endcase
    return v;
  endfunction

  // Spec-level model: phase 0 idle, 1 bursting, 2 in the low stretch after a burst.
  int m_phase, m_k, m_bc, m_low_left, m_mode, m_blen, m_glen;
  bit m_done, m_flag;

  task automatic model_step();
    bit beat, last;
    if (!rst_n) begin
      m_phase = 0; m_k = 0; m_bc = 0; m_low_left = 0;
      m_mode = 0; m_blen = 0; m_glen = 0; m_done = 0; m_flag = 0;
      return;
    end
    check("model_en", 32'(bus16.data_en), 32'(m_phase == 1));
    check("model_done", 32'(bus16.burst_done), 32'(m_done));
    if (m_phase == 1) check("model_data", 32'(bus16.data_in), 32'(m_word(m_mode, m_k) ^ 16'(m_flag)));

    beat = (m_phase == 1) && bus16.data_ready;
    last = beat && (m_blen != 0) && (m_bc + 1 == m_blen);
    case (m_phase)
      0: if (enable) begin
        m_phase = 1; m_mode = int'(mode); m_k = 0; m_bc = 0;
        m_blen = int'(burst_len); m_glen = int'(gap_len);
      end
      1: if (beat) begin
        m_k++;
        m_bc = last ? 0 : m_bc + 1;
        if (!enable) m_phase = 0;
        else if (last && m_glen > 0) begin m_phase = 2; m_low_left = m_glen + 1; end
        else if (last) begin m_blen = int'(burst_len); m_glen = int'(gap_len); end
      end
      default: begin
        m_low_left--;
        if (!enable) m_phase = 0;
        else if (m_low_left == 0) begin
          m_phase = 1; m_bc = 0; m_blen = int'(burst_len); m_glen = int'(gap_len);
        end
      end
    endcase
    m_done = last;
`ifdef PATTERN_GEN_ERR_INJ_EN
    m_flag = m_flag ? !beat : inject_err;
`endif
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  logic [15:0] obs[$];
  logic [7:0]  obs8[$];
  bit          en_tr[$];
  bit          dn_tr[$];

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bus16.data_en && bus16.data_ready) obs.push_back(bus16.data_in);
      if (bus8.data_en && bus8.data_ready) obs8.push_back(bus8.data_in);
      en_tr.push_back(bus16.data_en);
      dn_tr.push_back(bus16.burst_done);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input logic [1:0] md, input logic [7:0] bl, input logic [7:0] gl);
    mode = md; burst_len = bl; gap_len = gl; enable = 1'b1;
    tick(1);
    obs.delete(); en_tr.delete(); dn_tr.delete();
  endtask

  task automatic stop();
    enable = 1'b0;
    bus16.data_ready = 1'b1;
    tick(4);
    check("stop_idle", 32'(bus16.data_en), 32'd0);
  endtask

  localparam logic [10:0] GAP_EN = 11'b11110001111;
  localparam logic [10:0] GAP_DN = 11'b00001000000;
  logic [7:0] lfsr8_exp[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};
`ifdef PATTERN_GEN_ERR_INJ_EN
  logic [15:0] err_exp[9] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd7, 16'd7, 16'd8};
`else
  logic [15:0] err_exp[9] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
`endif

  initial begin
    int cnt_en, cnt_dn;
    enable = 1'b0; mode = 2'd0; burst_len = 8'd0; gap_len = 8'd0; inject_err = 1'b0; en8 = 1'b0;
    bus16.data_ready = 1'b1;
    bus8.data_ready  = 1'b1;

    #12;
    check("rst_en", 32'(bus16.data_en), 32'd0);
    check("rst_data", 32'(bus16.data_in), 32'd0);
    check("rst_done", 32'(bus16.burst_done), 32'd0);
    check("rst_data8", 32'(bus8.data_in), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick(2);

    check("pin_inc_wrap", 32'(m_word(0, 201)), 32'd1);
    check("pin_dec_wrap", 32'(m_word(1, 200)), 32'd199);
    check("pin_lfsr16", 32'(m_word(2, 16)), 32'h002D);
    check("pin_walk", 32'(m_word(3, 17)), 32'h0002);

    // Continuous increment across the wrap point.
    start(2'd0, 8'd0, 8'd0);
    tick(205);
    check("cont_count", 32'(obs.size() >= 202), 32'd1);
    for (int i = 0; i < 202 && i < obs.size(); i++) check("cont_word", 32'(obs[i]), 32'(i % 200));
    cnt_dn = 0;
    foreach (dn_tr[i]) cnt_dn += int'(dn_tr[i]);
    check("cont_no_done", 32'(cnt_dn), 32'd0);
    stop();

    // Burst of 4, gap of 2.
    start(2'd0, 8'd4, 8'd2);
    tick(11);
    for (int i = 0; i < 11 && i < en_tr.size(); i++) begin
      check("gap_en", 32'(en_tr[i]), 32'(GAP_EN[10-i]));
      check("gap_done", 32'(dn_tr[i]), 32'(GAP_DN[10-i]));
    end
    for (int i = 0; i < 8 && i < obs.size(); i++) check("gap_word", 32'(obs[i]), 32'(i));
    stop();

    // Backpressure at value 10, then enable dropped while stalled.
    start(2'd0, 8'd0, 8'd0);
    tick(10);
    check("bp_at10", 32'(bus16.data_in), 32'd10);
    bus16.data_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("bp_hold_en", 32'(bus16.data_en), 32'd1);
      check("bp_hold_data", 32'(bus16.data_in), 32'd10);
    end
    bus16.data_ready = 1'b1;
    tick(1);
    check("bp_resume", 32'(bus16.data_in), 32'd11);
    bus16.data_ready = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("drop_hold_en", 32'(bus16.data_en), 32'd1);
    end
    bus16.data_ready = 1'b1;
    tick(1);
    check("drop_after_beat", 32'(bus16.data_en), 32'd0);
    tick(2);
    check("drop_idle", 32'(bus16.data_en), 32'd0);

    // Restart reseeds; mode change mid-run is ignored.
    start(2'd1, 8'd0, 8'd0);
    check("dec_seed", 32'(bus16.data_in), 32'd199);
    mode = 2'd3;
    tick(1);
    check("dec_1", 32'(bus16.data_in), 32'd198);
    tick(1);
    check("dec_2", 32'(bus16.data_in), 32'd197);
    stop();

    // Walking one with a fixed stall pattern.
    start(2'd3, 8'd0, 8'd0);
    for (int i = 0; i < 40; i++) begin
      bus16.data_ready = (i % 3 != 2);
      tick(1);
    end
    bus16.data_ready = 1'b1;
    check("walk_count", 32'(obs.size() >= 17), 32'd1);
    if (obs.size() >= 17) begin
      check("walk_msb", 32'(obs[15]), 32'h8000);
      check("walk_rot", 32'(obs[16]), 32'h0001);
    end
    stop();

    // 16-bit LFSR in bursts of 5 with gap 1, stalls landing on burst ends.
    start(2'd2, 8'd5, 8'd1);
    for (int i = 0; i < 60; i++) begin
      bus16.data_ready = (i % 4 != 0);
      tick(1);
    end
    stop();

    // Zero gap: bursts of 3 back to back with no bubble.
    start(2'd0, 8'd3, 8'd0);
    tick(12);
    cnt_en = 0; cnt_dn = 0;
    for (int i = 0; i < 12 && i < en_tr.size(); i++) begin
      cnt_en += int'(en_tr[i]);
      cnt_dn += int'(dn_tr[i]);
    end
    check("nogap_en", 32'(cnt_en), 32'd12);
    check("nogap_done", 32'(cnt_dn), 32'd3);
    stop();

    // Error-inject pulse while 5 is on the bus.
    start(2'd0, 8'd0, 8'd0);
    tick(5);
    inject_err = 1'b1;
    tick(1);
    inject_err = 1'b0;
    tick(5);
    for (int i = 0; i < 9 && i < obs.size(); i++) check("err_word", 32'(obs[i]), 32'(err_exp[i]));
    stop();

    // 8-bit LFSR instance.
    obs8.delete();
    en8 = 1'b1;
    tick(11);
    check("lfsr8_count", 32'(obs8.size() >= 10), 32'd1);
    for (int i = 0; i < 10 && i < obs8.size(); i++) check("lfsr8_word", 32'(obs8[i]), 32'(lfsr8_exp[i]));
    en8 = 1'b0;

    // Asynchronous reset mid-burst.
    start(2'd0, 8'd0, 8'd0);
    tick(3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_en", 32'(bus16.data_en), 32'd0);
    check("arst_data", 32'(bus16.data_in), 32'd0);
    check("arst_done", 32'(bus16.burst_done), 32'd0);
    enable = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("arst_idle", 32'(bus16.data_en), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pattern_gen.md
# pattern_gen

Parametrised multi-mode stimulus source that produces a stream of DATA_W-bit words under a valid/ready handshake. It is organised as bursts separated by programmable idle gaps. It sits at the head of the ping-pong buffer datapath and feeds the write side with counting, LFSR or walking-one patterns. It replaces the fixed 16-bit 0..199 counter source and adds backpressure, burst framing and selectable patterns.

## Interface
Parameters:
- DATA_W, 16, data word width (2..32)
- WRAP_MAX, 199, counter wrap value for modes 0/1; must be < 2^DATA_W
- LFSR_POLY, 16'h002D, Galois feedback mask (DATA_W bits)
- LFSR_SEED, 1, LFSR start value; 0 is replaced by 1

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run request
- mode  in  2  pattern: 0 increment, 1 decrement, 2 LFSR, 3 walking-one
- burst_len  in  8  beats per burst; 0 = continuous (no gaps)
- gap_len  in  8  idle cycles between bursts
- inject_err  in  1  error-inject request (used only with PATTERN_GEN_ERR_INJ_EN)
- data_ready  in  1  consumer ready
- data_en  out  1  data valid
- data_in  out  DATA_W  data word (name kept for downstream compatibility)
- burst_done  out  1  one-cycle pulse after the last beat of a burst

## Operation
- Transfer (beat) = data_en & data_ready on a rising edge. The pattern advances only on a beat. data_in is held stable while data_en=1 and data_ready=0.
- FSM states: IDLE, BURST, GAP.
- IDLE: data_en=0.
  - When enable=1, latch mode, burst_len and gap_len, load the pattern seed and go to BURST.
  - Seed per mode: 0 -> 0, 1 -> WRAP_MAX, 2 -> LFSR_SEED, 3 -> 1.
- BURST: data_en=1. The beat counter increments on each beat.
  - On the beat that completes burst_len beats: pulse burst_done next cycle. If gap_len>0, go to GAP; otherwise start a new burst immediately with no bubble.
  - burst_len=0: the block stays in BURST and never pulses burst_done.
- GAP: data_en=0 for exactly gap_len cycles, then go to BURST.
  - The pattern continues from where it stopped; it is not reseeded.
  - Re-entry to BURST re-latches burst_len and gap_len but not mode.
- enable=0:
  - In BURST, data_en stays high until the current beat completes; then go to IDLE. Valid is never withdrawn without a beat.
  - In GAP, go to IDLE on the next edge.
- Pattern next-value rules:
  - mode 0: q>=WRAP_MAX -> 0, else q+1.
  - mode 1: q==0 -> WRAP_MAX, else q-1.
  - mode 2: next = {q[DATA_W-2:0],0} ^ (q[DATA_W-1] ? LFSR_POLY : 0).
  - mode 3: rotate left by 1.
- mode changes outside IDLE are ignored.

## Timing
- Reset values: data_en=0, data_in=0, burst_done=0, state IDLE, beat and gap counters 0.
- Reset asserted mid-burst clears everything asynchronously. Any in-flight beat is dropped.
- Start latency: enable sampled high in IDLE at edge N -> data_en=1 and data_in=seed after edge N.
- Beat at edge N -> next word on data_in after edge N. Throughput is 1 word/cycle with data_ready=1.
- Last beat at edge N -> burst_done=1 for the cycle after edge N.
  - With gap_len=G>0, data_en is low for G cycles. The first beat of the next burst is presentable after edge N+G+1.
- Backpressure during the last beat delays burst_done and the gap accordingly.

## Configuration
- PATTERN_GEN_ERR_INJ_EN defined:
  - inject_err=1 sampled on any edge arms a one-shot flag.
  - The next beat's word is driven with bit 0 inverted on data_in; the pattern state itself is uncorrupted.
  - The flag clears on that beat. Further requests while armed are merged.
- Macro undefined: inject_err is ignored, no flag logic is built, and data_in is always the pure pattern.

## Test plan
- Defaults, mode 0, burst_len=0, data_ready=1 -> 0,1,…,199,0,1 on consecutive cycles, with no burst_done.
- mode 0, burst_len=4, gap_len=2, data_ready=1:
  - data_en high 4 cycles (0..3), burst_done one cycle, low 2 cycles.
  - Next burst carries 4..7.
- data_ready=0 for 5 cycles mid-burst at value 10 -> data_in holds 10 and data_en stays high. Data resumes 11 after ready returns.
- DATA_W=8, LFSR_POLY=8'h1D, mode 2 -> 01,02,04,08,10,20,40,80,1D,3A.
- enable dropped while stalled in BURST -> data_en stays high until the beat completes, then goes low and the FSM returns to IDLE. Re-enable restarts from the seed.
- With PATTERN_GEN_ERR_INJ_EN, mode 0, inject_err pulse before beat value 6 -> observed 0..5,7(=6^1),7,8.
- Without the macro, the same stimulus observes 0..8 unmodified.
